// File: rtl/store_align_ctrl_pkg.sv
// store_align_ctrl_pkg: trim encodings, FSM states and lane-mask helper shared by the store and load paths
package store_align_ctrl_pkg;
  localparam logic [1:0] TRIM_WORD = 2'b00;
  localparam logic [1:0] TRIM_HALF = 2'b01;
  localparam logic [1:0] TRIM_BYTE = 2'b10;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  function automatic logic [3:0] base_mask(input logic [1:0] trim);
    return trim == TRIM_WORD ? 4'b1111 : trim == TRIM_BYTE ? 4'b0001 : trim == TRIM_HALF ? 4'b0011 : 4'b1111;
  endfunction
endpackage

// File: rtl/store_lane_gen.sv
// store_lane_gen: positions store data and byte strobes across a two-word (64-bit) lane window
module store_lane_gen
  import store_align_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  trim,
  input  logic [31:0] data,
  output logic [7:0]  mask,
  output logic [63:0] wide
);
  logic [31:0] keep;
  // zero the bytes the access width does not cover, then shift both mask and data by the byte offset
  always_comb begin
    keep = trim == TRIM_BYTE ? 32'h0000_00ff : trim == TRIM_HALF ? 32'h0000_ffff : 32'hffff_ffff;
    mask = {4'b0000, base_mask(trim)} << off;
    wide = {32'h0, data & keep} << {off, 3'b000};
  end
endmodule

// File: rtl/store_align_ctrl.sv
// store_align_ctrl: turns byte-addressed stores into one or two word-aligned bus beats
module store_align_ctrl
  import store_align_ctrl_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  trim_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        done_o,
  output logic        err_o
);
  state_t      state, state_d;
  logic [31:0] addr_q, data_q;
  logic [1:0]  trim_q;
  logic        done_q, done_d;
  logic [7:0]  mask;
  logic [63:0] wide;
  logic        split, reject;
  logic [31:0] beat0_addr, beat1_addr;

  store_lane_gen u_lane (
    .off  (addr_q[1:0]),
    .trim (trim_q),
    .data (data_q),
    .mask (mask),
    .wide (wide)
  );

  assign split      = |mask[7:4];
  assign reject     = split & ~SPLIT_EN;
  assign beat0_addr = {addr_q[31:2], 2'b00};
  assign beat1_addr = beat0_addr + 32'd4;
  assign done_o     = done_q;

  // state, captured request and registered completion pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      trim_q <= TRIM_WORD;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= done_d;
      if (req_valid_i && req_ready_o) begin
        addr_q <= addr_i;
        data_q <= data_i;
        trim_q <= trim_i;
      end
    end
  end

  // next state and bus outputs; beat fields read as zero whenever no beat is offered
  always_comb begin
    req_ready_o = state == IDLE;
    mem_valid_o = (state == BEAT0 && !reject) || state == BEAT1;
    err_o       = state == BEAT0 && reject;
    state_d     = state == IDLE  ? (req_valid_i ? BEAT0 : IDLE) :
                  state == BEAT0 ? (reject ? IDLE : mem_ready_i ? (split ? BEAT1 : IDLE) : BEAT0) :
                  state == BEAT1 ? (mem_ready_i ? IDLE : BEAT1) : IDLE;
    done_d      = mem_valid_o && mem_ready_i && (state == BEAT1 || !split);
    mem_addr_o  = !mem_valid_o ? 32'h0 : state == BEAT1 ? beat1_addr : beat0_addr;
    mem_wdata_o = !mem_valid_o ? 32'h0 : state == BEAT1 ? wide[63:32] : wide[31:0];
    mem_wstrb_o = !mem_valid_o ? 4'h0 : state == BEAT1 ? mask[7:4] : mask[3:0];
  end
endmodule

// File: tb/tb_store_align_ctrl.sv
// tb_store_align_ctrl: directed vectors with hand-computed beats for store_align_ctrl
module tb_store_align_ctrl;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid = 1'b0, req_valid2 = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;
  logic [1:0]  trim_i = 2'b00;
  logic        mem_ready = 1'b1;
  logic        req_ready, mem_valid, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        req_ready2, mem_valid2, done2, err2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [3:0]  mem_wstrb2;
  int          n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  store_align_ctrl #(.SPLIT_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .addr_i(addr_i), .data_i(data_i), .trim_i(trim_i), .mem_valid_o(mem_valid),
    .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb), .done_o(done), .err_o(err)
  );

  store_align_ctrl #(.SPLIT_EN(1'b0)) u_nosplit (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
    .addr_i(addr_i), .data_i(data_i), .trim_i(trim_i), .mem_valid_o(mem_valid2),
    .mem_ready_i(mem_ready), .mem_addr_o(mem_addr2), .mem_wdata_o(mem_wdata2),
    .mem_wstrb_o(mem_wstrb2), .done_o(done2), .err_o(err2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                       input logic [31:0] a0, input logic [31:0] w0, input logic [3:0] s0,
                       input bit sp, input logic [31:0] a1, input logic [31:0] w1, input logic [3:0] s1);
    addr_i = a; data_i = d; trim_i = t; req_valid = 1'b1;
    chk("req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; addr_i = ~a; data_i = ~d; trim_i = ~t;
    chk("b0_valid", mem_valid, 1);
    chk("b0_addr", mem_addr, a0);
    chk("b0_strb", mem_wstrb, s0);
    chk("b0_wdata", mem_wdata, w0);
    chk("b0_busy", req_ready, 0);
    @(posedge clk); #1;
    if (sp) begin
      chk("b1_valid", mem_valid, 1);
      chk("b1_addr", mem_addr, a1);
      chk("b1_strb", mem_wstrb, s1);
      chk("b1_wdata", mem_wdata, w1);
      chk("b1_nodone", done, 0);
      @(posedge clk); #1;
    end
    chk("done", done, 1);
    chk("err", err, 0);
    chk("idle_valid", mem_valid, 0);
    chk("idle_strb", mem_wstrb, 0);
    chk("idle_ready", req_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", mem_valid, 0);
    chk("rst_strb", mem_wstrb, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #1;
    store(32'h0000_1003, 32'h0000_00AB, 2'b10, 32'h0000_1000, 32'hAB00_0000, 4'b1000, 0, '0, '0, '0);
    store(32'h0000_2002, 32'h1122_3344, 2'b00, 32'h0000_2000, 32'h3344_0000, 4'b1100, 1, 32'h0000_2004, 32'h0000_1122, 4'b0011);
    store(32'hFFFF_FFFF, 32'h1234_BEEF, 2'b01, 32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000, 1, 32'h0000_0000, 32'h0000_00BE, 4'b0001);
    store(32'h0000_4000, 32'hCAFE_F00D, 2'b00, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 0, '0, '0, '0);
    store(32'h0000_5001, 32'hFFFF_A5A5, 2'b01, 32'h0000_5000, 32'h00A5_A500, 4'b0110, 0, '0, '0, '0);
    store(32'h0000_6000, 32'h0102_0304, 2'b11, 32'h0000_6000, 32'h0102_0304, 4'b1111, 0, '0, '0, '0);
    store(32'h0000_7002, 32'h5566_7788, 2'b01, 32'h0000_7000, 32'h7788_0000, 4'b1100, 0, '0, '0, '0);
    store(32'h0000_8003, 32'h9988_CAFE, 2'b01, 32'h0000_8000, 32'hFE00_0000, 4'b1000, 1, 32'h0000_8004, 32'h0000_00CA, 4'b0001);
    mem_ready = 1'b0;
    addr_i = 32'h0000_2002; data_i = 32'h1122_3344; trim_i = 2'b00; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", mem_valid, 1);
      chk("stall_addr", mem_addr, 32'h0000_2000);
      chk("stall_strb", mem_wstrb, 4'b1100);
      chk("stall_wdata", mem_wdata, 32'h3344_0000);
      chk("stall_ready", req_ready, 0);
      chk("stall_done", done, 0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_b1_addr", mem_addr, 32'h0000_2004);
    chk("stall_b1_strb", mem_wstrb, 4'b0011);
    chk("stall_b1_done", done, 0);
    @(posedge clk); #1;
    chk("stall_done_end", done, 1);
    addr_i = 32'h0000_3001; data_i = 32'hDEAD_BEEF; trim_i = 2'b00; req_valid2 = 1'b1;
    chk("rej_ready", req_ready2, 1);
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    chk("rej_err", err2, 1);
    chk("rej_valid", mem_valid2, 0);
    chk("rej_strb", mem_wstrb2, 0);
    chk("rej_done", done2, 0);
    @(posedge clk); #1;
    chk("rej_err_off", err2, 0);
    chk("rej_ready_back", req_ready2, 1);
    chk("rej_done_off", done2, 0);
    chk("rej_valid_off", mem_valid2, 0);
    addr_i = 32'h0000_2002; data_i = 32'h1122_3344; trim_i = 2'b00; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_b1_valid", mem_valid, 1);
    chk("rst_b1_addr", mem_addr, 32'h0000_2004);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", mem_valid, 0);
    chk("arst_strb", mem_wstrb, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_ready", req_ready, 1);
    chk("arst_done", done, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    chk("post_rst_done", done, 0);
    chk("post_rst_valid", mem_valid, 0);
    store(32'h0000_1003, 32'h0000_00AB, 2'b10, 32'h0000_1000, 32'hAB00_0000, 4'b1000, 0, '0, '0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/store_align_ctrl.md
STORE_ALIGN_CTRL -- requirements
Module: store_align_ctrl

Interface
REQ-001 SHALL have parameter SPLIT_EN, default 1: 1 = misaligned stores split into two bus beats; 0 = misaligned stores rejected via err_o.
REQ-002 SHALL provide ports, one per line:
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  store request valid.
- req_ready_o  out  1  request accepted when both high.
- addr_i  in  32  byte address of store.
- data_i  in  32  store data, right-justified.
- trim_i  in  2  width: 00 word, 01 half, 10 byte, 11 word.
- mem_valid_o  out  1  bus beat valid.
- mem_ready_i  in  1  bus beat accepted when both high.
- mem_addr_o  out  32  word-aligned beat address, bits [1:0] = 0.
- mem_wdata_o  out  32  lane-positioned write data.
- mem_wstrb_o  out  4  byte-lane write strobes.
- done_o  out  1  one-cycle pulse, store complete.
- err_o  out  1  one-cycle pulse, misaligned store rejected (SPLIT_EN=0 only).

Function
REQ-003 SHALL implement FSM states IDLE, BEAT0, BEAT1; req_ready_o = 1 only in IDLE.
REQ-004 On request handshake, SHALL register addr_i, data_i and trim_i; later input changes have no effect until the next IDLE.
REQ-005 Base mask: byte 0001, half 0011, word 1111. With off = addr[1:0]: 8-bit mask = base << off; 64-bit data = data << (8*off). Unused data bits SHALL be zero.
REQ-006 Beat0: addr = {addr[31:2],00}, strobe = mask[3:0], wdata = data[31:0]. Beat1: addr = beat0 addr + 4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), strobe = mask[7:4], wdata = data[63:32].
REQ-007 Split SHALL be required iff mask[7:4] != 0: half at off 3, or word at off 1-3.
REQ-008 Transitions:
- IDLE->BEAT0 on accept.
- BEAT0->BEAT1 on beat handshake if split required.
- Otherwise BEAT0->IDLE with done_o high for the next cycle.
- BEAT1->IDLE on handshake, with done_o high for the next cycle.
REQ-009 mem_valid_o SHALL be high in BEAT0/BEAT1 from the cycle after entry; mem_addr_o, mem_wdata_o and mem_wstrb_o SHALL stay stable while mem_valid_o=1 and mem_ready_i=0.
REQ-010 Latency: accept in cycle N gives mem_valid_o in cycle N+1. An aligned store with mem_ready_i tied high gives done_o in N+2. A split store gives done_o in N+3.
REQ-011 SPLIT_EN=0 with split required: SHALL issue no bus beat, pulse err_o in cycle N+1, and return to IDLE; done_o stays 0.
REQ-012 done_o and err_o SHALL never be high together, and each SHALL be exactly one cycle.
REQ-013 Back-to-back: a new request may be accepted in the same cycle done_o is high (FSM is in IDLE).
REQ-014 While mem_valid_o=0, mem_wstrb_o SHALL be 0000.

Reset
REQ-015 rst_ni low SHALL immediately (asynchronously) force IDLE, mem_valid_o=0, mem_wstrb_o=0000, mem_addr_o=0, mem_wdata_o=0, done_o=0, err_o=0, and req_ready_o=1 once in IDLE.
REQ-016 Reset during BEAT0/BEAT1 SHALL abandon the store with no done_o; the first beat of a split store may already be written.

Structure
REQ-017 Shared package SHALL hold trim encodings (TRIM_WORD/HALF/BYTE) and the FSM state enum; the load-path sign/trim logic SHALL use the same trim constants.
REQ-018 Lane mask/shift logic SHALL be a combinational sub-module store_lane_gen (inputs off, trim, data; outputs 8-bit mask, 64-bit data); the FSM and registers live in store_align_ctrl.

Verification
REQ-019 Byte store, addr 0x1003, data 0x000000AB, ready high -> one beat: addr 0x1000, wstrb 1000, wdata 0xAB000000; done_o at N+2.
REQ-020 Word store, addr 0x2002, data 0x11223344 -> beat0: 0x2000, wstrb 1100, wdata 0x33440000; beat1: 0x2004, wstrb 0011, wdata 0x00001122; done_o at N+3.
REQ-021 Half store, addr 0xFFFFFFFF, data 0xBEEF -> beat0: 0xFFFFFFFC, wstrb 1000, wdata 0xEF000000; beat1: 0x00000000, wstrb 0001, wdata 0x000000BE.
REQ-022 mem_ready_i held low 5 cycles during beat0 of REQ-020 -> outputs stable all 5 cycles; req_ready_o=0; no done_o until both beats complete.
REQ-023 SPLIT_EN=0, word store at addr 0x3001 -> no mem_valid_o, err_o pulse at N+1, req_ready_o=1 at N+2.
REQ-024 rst_ni asserted during BEAT1 of REQ-020 -> mem_valid_o drops the same cycle, no done_o, and a new byte store completes normally after release.
